// File: rtl/pixel_packer_if.sv
// pixel_packer_if: pixel stream in, packed word write port and status out.
interface pixel_packer_if #(
    parameter int BITWIDTH   = 8,
    parameter int COLS       = 640,
    parameter int ROWS       = 480,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 20
);
    logic                          pix_valid;
    logic [BITWIDTH-1:0]           pix_data;
    logic [$clog2(COLS):0]         pix_x;
    logic [$clog2(ROWS):0]         pix_y;
    logic                          wr_valid;
    logic                          wr_ready;
    logic [PACK*BITWIDTH-1:0]      wr_data;
    logic [AW-1:0]                 wr_addr;
    logic                          frame_done;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          ovf;
    logic                          sync_err;
    logic                          err_clr;
    modport master (
        output pix_valid, pix_data, pix_x, pix_y, wr_ready, err_clr,
        input  wr_valid, wr_data, wr_addr, frame_done, fifo_level, ovf, sync_err
    );
    modport slave (
        input  pix_valid, pix_data, pix_x, pix_y, wr_ready, err_clr,
        output wr_valid, wr_data, wr_addr, frame_done, fifo_level, ovf, sync_err
    );
endinterface

// File: rtl/pixel_packer.sv
// pixel_packer: packs PACK pixels per word and queues {addr, word} in a fall-through FIFO.
module pixel_packer #(
    parameter int BITWIDTH   = 8,
    parameter int COLS       = 640,
    parameter int ROWS       = 480,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 20
) (
    input  logic clk,
    input  logic rst,
    pixel_packer_if.slave bus
);
    localparam int LW = $clog2(PACK);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int XW = $clog2(COLS) + 1;
    localparam int YW = $clog2(ROWS) + 1;
    localparam int DW = PACK * BITWIDTH;
    logic [LW-1:0]                    lane_cnt, li;
    logic [PACK-1:0][BITWIDTH-1:0]    lanes, lanes_w;
    logic [AW-1:0]                    addr_cnt, addr_w;
    logic                             fs, fe, push, pop, full, do_push;
    logic [DW-1:0]                    mem_data [FIFO_DEPTH];
    logic [AW-1:0]                    mem_addr [FIFO_DEPTH];
    logic                             mem_last [FIFO_DEPTH];
    logic [PW-1:0]                    wp, rp;
    logic [PW:0]                      level;
    // A frame-start pixel restarts the word from lane 0, discarding any partial lanes.
    always_comb begin
        fs = bus.pix_x == XW'(0) && bus.pix_y == YW'(0);
        fe = bus.pix_x == XW'(COLS - 1) && bus.pix_y == YW'(ROWS - 1);
        li = fs ? '0 : lane_cnt;
        addr_w = fs ? '0 : addr_cnt;
        lanes_w = fs ? '0 : lanes;
        lanes_w[li] = bus.pix_data;
        push = bus.pix_valid && (li == LW'(PACK - 1) || fe);
        full = level == (PW + 1)'(FIFO_DEPTH);
        pop = level != '0 && bus.wr_ready;
        do_push = push && (!full || pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_cnt <= '0;
            lanes <= '0;
            addr_cnt <= '0;
            wp <= '0;
            rp <= '0;
            level <= '0;
            bus.frame_done <= 1'b0;
            bus.ovf <= 1'b0;
            bus.sync_err <= 1'b0;
        end else begin
            if (bus.pix_valid) begin
                lane_cnt <= push ? '0 : li + 1'b1;
                lanes <= push ? '0 : lanes_w;
                addr_cnt <= push ? addr_w + 1'b1 : addr_w;
            end
            if (do_push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level <= (do_push && !pop) ? level + 1'b1 : (pop && !do_push) ? level - 1'b1 : level;
            bus.frame_done <= pop && mem_last[rp];
            // A new error event outranks a simultaneous clear.
            bus.ovf <= (push && full && !pop) || (bus.ovf && !bus.err_clr);
            bus.sync_err <= (bus.pix_valid && fs && lane_cnt != '0) || (bus.sync_err && !bus.err_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wp] <= lanes_w;
            mem_addr[wp] <= addr_w;
            mem_last[wp] <= fe;
        end
    end
    assign bus.wr_valid = level != '0;
    assign bus.wr_data = bus.wr_valid ? mem_data[rp] : '0;
    assign bus.wr_addr = bus.wr_valid ? mem_addr[rp] : '0;
    assign bus.fifo_level = level;
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed checks on an 8x2 frame instance and a 6x1 frame instance.
module tb_pixel_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    pixel_packer_if #(.BITWIDTH(8), .COLS(8), .ROWS(2), .PACK(4), .FIFO_DEPTH(4), .AW(20)) bus0 ();
    pixel_packer_if #(.BITWIDTH(8), .COLS(6), .ROWS(1), .PACK(4), .FIFO_DEPTH(4), .AW(20)) bus1 ();
    pixel_packer #(.BITWIDTH(8), .COLS(8), .ROWS(2), .PACK(4), .FIFO_DEPTH(4), .AW(20)) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    pixel_packer #(.BITWIDTH(8), .COLS(6), .ROWS(1), .PACK(4), .FIFO_DEPTH(4), .AW(20)) u1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send0(input logic [7:0] d, input int x, input int y);
        bus0.pix_valid = 1'b1;
        bus0.pix_data = d;
        bus0.pix_x = 4'(x);
        bus0.pix_y = 2'(y);
        @(posedge clk);
        #1 bus0.pix_valid = 1'b0;
    endtask
    task automatic send1(input logic [7:0] d, input int x);
        bus1.pix_valid = 1'b1;
        bus1.pix_data = d;
        bus1.pix_x = 4'(x);
        bus1.pix_y = 1'b0;
        @(posedge clk);
        #1 bus1.pix_valid = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    function automatic logic [63:0] word(input int k);
        return 64'({8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1)});
    endfunction
    initial begin
        bus0.pix_valid = 0; bus0.pix_data = 0; bus0.pix_x = 0; bus0.pix_y = 0;
        bus0.wr_ready = 0; bus0.err_clr = 0;
        bus1.pix_valid = 0; bus1.pix_data = 0; bus1.pix_x = 0; bus1.pix_y = 0;
        bus1.wr_ready = 0; bus1.err_clr = 0;
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", 64'(bus0.wr_valid), 64'd0);
        chk("rst_level", 64'(bus0.fifo_level), 64'd0);
        chk("rst_data", 64'(bus0.wr_data), 64'd0);
        chk("rst_addr", 64'(bus0.wr_addr), 64'd0);
        chk("rst_flags", 64'({bus0.ovf, bus0.sync_err, bus0.frame_done}), 64'd0);
        #10 rst = 1'b1;
        idle(1);
        // Streaming with the consumer always ready
        bus0.wr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send0(8'(i + 1), i % 8, i / 8);
            if (i % 4 == 3) begin
                chk("t1_valid", 64'(bus0.wr_valid), 64'd1);
                chk("t1_data", 64'(bus0.wr_data), word(i / 4));
                chk("t1_addr", 64'(bus0.wr_addr), 64'(i / 4));
            end else if (i % 4 == 0 && i > 0) begin
                chk("t1_popped", 64'(bus0.wr_valid), 64'd0);
            end
        end
        chk("t1_fd_early", 64'(bus0.frame_done), 64'd0);
        idle(1);
        chk("t1_fd", 64'(bus0.frame_done), 64'd1);
        chk("t1_level", 64'(bus0.fifo_level), 64'd0);
        idle(1);
        chk("t1_fd_pulse", 64'(bus0.frame_done), 64'd0);
        // Consumer stalled, then released
        bus0.wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send0(8'(i + 1), i % 8, i / 8);
            if (i == 7) begin
                chk("t2_level_mid", 64'(bus0.fifo_level), 64'd2);
                chk("t2_hold_mid", 64'(bus0.wr_data), 64'h04030201);
            end
        end
        chk("t2_level", 64'(bus0.fifo_level), 64'd4);
        chk("t2_hold", 64'(bus0.wr_data), 64'h04030201);
        chk("t2_addr", 64'(bus0.wr_addr), 64'd0);
        chk("t2_ovf", 64'(bus0.ovf), 64'd0);
        bus0.wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_pop_addr", 64'(bus0.wr_addr), 64'(k));
            chk("t2_pop_data", 64'(bus0.wr_data), word(k));
            idle(1);
        end
        chk("t2_empty", 64'(bus0.fifo_level), 64'd0);
        chk("t2_fd", 64'(bus0.frame_done), 64'd1);
        // Overflow: 20 words into a 4-deep FIFO
        bus0.wr_ready = 1'b0;
        for (int i = 0; i < 80; i++) begin
            send0(8'(i % 16 + 1), i % 8, (i / 8) % 2);
            if (i == 15) begin
                chk("t3_full", 64'(bus0.fifo_level), 64'd4);
                chk("t3_no_ovf", 64'(bus0.ovf), 64'd0);
            end
            if (i == 19) chk("t3_ovf", 64'(bus0.ovf), 64'd1);
        end
        chk("t3_level", 64'(bus0.fifo_level), 64'd4);
        bus0.wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_addr", 64'(bus0.wr_addr), 64'(k));
            chk("t3_data", 64'(bus0.wr_data), word(k));
            idle(1);
        end
        chk("t3_empty", 64'(bus0.fifo_level), 64'd0);
        chk("t3_fd", 64'(bus0.frame_done), 64'd1);
        bus0.err_clr = 1'b1;
        idle(1);
        bus0.err_clr = 1'b0;
        chk("t3_clr", 64'(bus0.ovf), 64'd0);
        // Push and pop on the same edge with a full FIFO
        bus0.wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) send0(8'(i + 1), i % 8, i / 8);
        chk("t4_full", 64'(bus0.fifo_level), 64'd4);
        send0(8'h21, 0, 0);
        send0(8'h22, 1, 0);
        send0(8'h23, 2, 0);
        bus0.wr_ready = 1'b1;
        send0(8'h24, 3, 0);
        chk("t4_level", 64'(bus0.fifo_level), 64'd4);
        chk("t4_ovf", 64'(bus0.ovf), 64'd0);
        chk("t4_head_addr", 64'(bus0.wr_addr), 64'd1);
        chk("t4_head_data", 64'(bus0.wr_data), 64'h08070605);
        idle(3);
        chk("t4_new_addr", 64'(bus0.wr_addr), 64'd0);
        chk("t4_new_data", 64'(bus0.wr_data), 64'h24232221);
        idle(1);
        chk("t4_empty", 64'(bus0.fifo_level), 64'd0);
        // Frame restart with a partial word pending
        send0(8'h31, 0, 0);
        send0(8'h32, 1, 0);
        send0(8'h33, 0, 0);
        chk("t5_sync", 64'(bus0.sync_err), 64'd1);
        chk("t5_nopush", 64'(bus0.wr_valid), 64'd0);
        send0(8'h34, 1, 0);
        send0(8'h35, 2, 0);
        send0(8'h36, 3, 0);
        chk("t5_valid", 64'(bus0.wr_valid), 64'd1);
        chk("t5_data", 64'(bus0.wr_data), 64'h36353433);
        chk("t5_addr", 64'(bus0.wr_addr), 64'd0);
        bus0.err_clr = 1'b1;
        idle(1);
        bus0.err_clr = 1'b0;
        chk("t5_clr", 64'(bus0.sync_err), 64'd0);
        send0(8'h41, 0, 0);
        bus0.err_clr = 1'b1;
        send0(8'h42, 0, 0);
        bus0.err_clr = 1'b0;
        chk("t5_event_wins", 64'(bus0.sync_err), 64'd1);
        // Short frame with a partial final word, then reset mid-frame
        bus1.wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send1(8'(8'hA1 + i), i);
            if (i == 3) begin
                chk("t6_w0_data", 64'(bus1.wr_data), 64'hA4A3A2A1);
                chk("t6_w0_addr", 64'(bus1.wr_addr), 64'd0);
            end
        end
        chk("t6_w1_data", 64'(bus1.wr_data), 64'h0000A6A5);
        chk("t6_w1_addr", 64'(bus1.wr_addr), 64'd1);
        chk("t6_fd_early", 64'(bus1.frame_done), 64'd0);
        idle(1);
        chk("t6_fd", 64'(bus1.frame_done), 64'd1);
        chk("t6_empty", 64'(bus1.fifo_level), 64'd0);
        bus1.wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) send1(8'(8'hA1 + i), i);
        chk("t6_level", 64'(bus1.fifo_level), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus1.wr_valid), 64'd0);
        chk("t6_rst_level", 64'(bus1.fifo_level), 64'd0);
        chk("t6_rst_data", 64'(bus1.wr_data), 64'd0);
        chk("t6_rst_sync", 64'(bus0.sync_err), 64'd0);
        #4 rst = 1'b1;
        idle(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
- Downstream stage of the 2-D image filter.
- Consumes the filter's pixel stream (data, valid, column/row coordinates) and packs PACK consecutive pixels into one wide word.
- Buffers packed words in a small FIFO and presents them on a valid/ready write port with a frame-relative word address for the frame-buffer writer.
- Upstream has no backpressure, so the block detects and flags overflow and frame-sync errors.

Parameters:
- BITWIDTH, 8, bits per pixel.
- COLS, 640, pixels per row.
- ROWS, 480, rows per frame.
- PACK, 4, pixels per output word (power of two, >=2).
- FIFO_DEPTH, 16, FIFO entries (power of two).
- AW, 20, word-address width (must cover COLS*ROWS/PACK).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel strobe from filter.
- pix_data  in  BITWIDTH  filtered pixel.
- pix_x  in  clog2(COLS)+1  column of pix_data.
- pix_y  in  clog2(ROWS)+1  row of pix_data.
- wr_valid  out  1  FIFO head word available.
- wr_ready  in  1  consumer accepts head word.
- wr_data  out  PACK*BITWIDTH  packed pixels; lane 0 = earliest pixel, in LSBs.
- wr_addr  out  AW  word index within frame.
- frame_done  out  1  one-cycle pulse when last word of a frame is popped.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky: packed word dropped because FIFO was full.
- sync_err  out  1  sticky: frame restart seen with a partial word pending.
- err_clr  in  1  synchronous clear of ovf and sync_err.

Behaviour:
- Reset (rst=0, async): all outputs 0; lane counter, word address, FIFO pointers, and level cleared. wr_data/wr_addr read 0.
- Pack register: each pix_valid writes pix_data into lane[lane_cnt], then lane_cnt increments.
- When the PACK-th lane fills, or a frame-end pixel is accepted, the word {addr_cnt, lanes} is pushed on the next edge. Push cycle = acceptance cycle +1.
- After each push, lane_cnt returns to 0 and addr_cnt increments. Unfilled lanes of a frame-end word are zero.
- Frame start: pix_valid with pix_x==0 && pix_y==0.
  - If lane_cnt==0, nothing special happens.
  - If lane_cnt!=0, the partial word is discarded (never pushed) and sync_err is set.
  - In both cases addr_cnt resets to 0 and the pixel goes to lane 0 of word 0.
- Frame end: pix_valid with pix_x==COLS-1 && pix_y==ROWS-1. The word is flushed as above, and that entry is tagged last.
- FIFO: first-word fall-through.
  - wr_valid = (level != 0). wr_data/wr_addr show the head entry.
  - Head entry is held stable while wr_valid && !wr_ready.
  - Pop occurs when wr_valid && wr_ready.
  - Push into an empty FIFO at edge N gives wr_valid=1 in cycle N (the cycle after acceptance of the completing pixel).
- Full FIFO:
  - A push with a simultaneous pop is accepted; level is unchanged.
  - A push without a pop is dropped and ovf is set. addr_cnt still advances, so later words keep correct addresses.
- frame_done pulses in the cycle after the pop of an entry tagged last. If that entry was dropped, no pulse occurs.
- err_clr clears the sticky flags. If err_clr coincides with a new error event, the flag is set (event wins).
- addr_cnt wraps modulo 2^AW. There is no check against COLS*ROWS; frame markers govern.
- Pixels with pix_valid=0 are ignored regardless of pix_x/pix_y.
- Reset mid-stream discards pack-register and FIFO contents immediately.

Test Plan:
1. COLS=8, ROWS=2, PACK=4, wr_ready=1, 16 consecutive pixels 0x01..0x10 from (0,0) → 4 words: 0x04030201@0, 0x08070605@1, 0x0C0B0A09@2, 0x100F0E0D@3; frame_done 1 cycle after the addr-3 pop; each wr_valid 1 cycle after its 4th pixel.
2. Same stream, wr_ready=0 throughout → level climbs to 4, wr_data holds 0x04030201@0 steady; ovf stays 0. Then wr_ready=1 → 4 pops in 4 cycles, level 0.
3. FIFO_DEPTH=4, wr_ready=0, 5 frames' worth of words (20 words) → level saturates at 4; ovf=1 at 5th push. Release → addresses 0,1,2,3 only; err_clr → ovf=0.
4. Full FIFO, wr_ready=1 on the same cycle as a push → push accepted, level stays 4, ovf=0.
5. Send 2 pixels, then a pixel at (0,0) → sync_err=1, no word pushed for the 2 pixels; next completed word has addr 0 and lane 0 = the (0,0) pixel.
6. COLS=6, ROWS=1, PACK=4, 6 pixels 0xA1..0xA6 → words 0xA4A3A2A1@0, 0x0000A6A5@1; frame_done after second pop. Assert rst mid-frame → wr_valid=0, fifo_level=0 immediately.
